thread_datapath_top: RTL and testbench



---
 rtl/thread_datapath_top_if.sv | 12 +
 rtl/thread_datapath_top.sv | 185 ++++++++++++++++++
 tb/tb_thread_datapath_top.sv | 121 ++++++++++++
 3 files changed

// File: rtl/thread_datapath_top_if.sv
// Observation bus of the single-thread datapath: program counter, halt flag
// and retired-instruction count.
interface thread_datapath_top_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] pc;
    logic              done;
    logic [7:0]        retired;

    modport master (output pc, done, retired);
    modport slave  (input  pc, done, retired);
endinterface

// File: rtl/thread_datapath_top.sv
// Standalone MiniGPU thread datapath: PC, built-in ROM kernel, register file,
// ALU, NZP flags and a load/store unit on an internal RAM. Define
// THREAD_TRACE_EN to print a per-instruction retire trace in simulation.
//
// state   | meaning
// FETCH   | latch ROM[pc]
// DECODE  | read rs/rt operands
// EXECUTE | ALU result or memory address/data capture
// MEMWAIT | LDR/STR RAM access
// UPDATE  | writeback, NZP, pc update, retired+1
// DONE    | halted after RET
module thread_datapath_top #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int THREAD_ID = 0,
    parameter int BLOCK_ID  = 0,
    parameter int BLOCK_DIM = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    thread_datapath_top_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEMWAIT = 3'd3,
        UPDATE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR    = 4'h1;
    localparam logic [3:0] OP_CMP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_LDR   = 4'h7;
    localparam logic [3:0] OP_STR   = 4'h8;
    localparam logic [3:0] OP_CONST = 4'h9;
    localparam logic [3:0] OP_RET   = 4'hF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic                done_q;
    logic [7:0]          retired_q;
    logic [2:0]          nzp_q, cmp_q;
    logic [15:0]         instr_q;
    logic [DATA_W-1:0]   rs_val_q, rt_val_q, result_q, mem_wdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   regs_q [13];
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    logic [3:0]          op, rd, rs, rt;
    logic [DATA_W-1:0]   alu_res;
    logic [2:0]          alu_nzp;
    logic                wr_en, br_taken;

    assign op = instr_q[15:12];
    assign rd = instr_q[11:8];
    assign rs = instr_q[7:4];
    assign rt = instr_q[3:0];

    // Addresses past the kernel decode as RET so a runaway pc halts.
    function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(0):  rom_word = 16'h9008;
            ADDR_W'(1):  rom_word = 16'h9103;
            ADDR_W'(2):  rom_word = 16'h3201;
            ADDR_W'(3):  rom_word = 16'h5321;
            ADDR_W'(4):  rom_word = 16'h8003;
            ADDR_W'(5):  rom_word = 16'h7400;
            ADDR_W'(6):  rom_word = 16'h4540;
            ADDR_W'(7):  rom_word = 16'h2051;
            ADDR_W'(8):  rom_word = 16'h120A;
            ADDR_W'(9):  rom_word = 16'h9601;
            default:     rom_word = 16'hF000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] reg_read(input logic [3:0] idx);
        case (idx)
            4'd13:   reg_read = DATA_W'(BLOCK_ID);
            4'd14:   reg_read = DATA_W'(BLOCK_DIM);
            4'd15:   reg_read = DATA_W'(THREAD_ID);
            default: reg_read = regs_q[idx];
        endcase
    endfunction

    always_comb begin
        alu_res = '0;
        alu_nzp = nzp_q;
        case (op)
            OP_ADD:   alu_res = rs_val_q + rt_val_q;
            OP_SUB:   alu_res = rs_val_q - rt_val_q;
            OP_MUL:   alu_res = rs_val_q * rt_val_q;
            OP_DIV:   alu_res = (rt_val_q == '0) ? '1 : rs_val_q / rt_val_q;
            OP_CONST: alu_res = DATA_W'(instr_q[7:0]);
            OP_CMP:   alu_nzp = {rs_val_q < rt_val_q, rs_val_q == rt_val_q,
                                 rs_val_q > rt_val_q};
            default:  alu_res = '0;
        endcase
    end

    assign wr_en = (op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV ||
                    op == OP_CONST || op == OP_LDR) && (rd < 4'd13);
    assign br_taken = (op == OP_BR) && ((instr_q[11:9] & nzp_q) != 3'b000);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = (op == OP_LDR || op == OP_STR) ? MEMWAIT : UPDATE;
            MEMWAIT: state_d = UPDATE;
            UPDATE:  state_d = (op == OP_RET) ? DONE : FETCH;
            DONE:    state_d = DONE;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            done_q      <= 1'b0;
            retired_q   <= '0;
            nzp_q       <= '0;
            cmp_q       <= '0;
            instr_q     <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            result_q    <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            for (int i = 0; i < 13; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FETCH:   instr_q <= rom_word(pc_q);
                DECODE: begin
                    rs_val_q <= reg_read(rs);
                    rt_val_q <= reg_read(rt);
                end
                EXECUTE: begin
                    result_q    <= alu_res;
                    cmp_q       <= alu_nzp;
                    mem_addr_q  <= ADDR_W'(rs_val_q);
                    mem_wdata_q <= rt_val_q;
                end
                MEMWAIT: if (op == OP_LDR) result_q <= mem_q[mem_addr_q];
                UPDATE: begin
                    retired_q <= retired_q + 8'd1;
                    if (wr_en) regs_q[rd] <= result_q;
                    if (op == OP_CMP) nzp_q <= cmp_q;
                    if (op == OP_RET) done_q <= 1'b1;
                    else if (br_taken) pc_q <= ADDR_W'(instr_q[7:0]);
                    else pc_q <= pc_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately left out of reset; an aborted STR never reaches MEMWAIT.
    always_ff @(posedge clock) begin
        if (state_q == MEMWAIT && op == OP_STR) mem_q[mem_addr_q] <= mem_wdata_q;
    end

`ifdef THREAD_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset && state_q == UPDATE) begin
            $display("retire pc=%0d op=%h rd=%0d val=%0d", pc_q, op, rd, result_q);
            if (op == OP_RET)
                $display("halt R0=%0d R1=%0d R2=%0d R3=%0d R4=%0d R5=%0d R6=%0d NZP=%b",
                         regs_q[0], regs_q[1], regs_q[2], regs_q[3], regs_q[4],
                         regs_q[5], regs_q[6], nzp_q);
        end
    end
`endif

    assign bus.pc      = pc_q;
    assign bus.done    = done_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_thread_datapath_top.sv
// Directed bench for thread_datapath_top: reset, full kernel run with cycle
// timing, mid-instruction reset abort, and post-halt hold.
module tb_thread_datapath_top;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_pc1, t_pc4, t_pc5, t_pc8, t_pc10, t_done;
    int   saw9;

    thread_datapath_top_if #(.ADDR_W(8)) bus ();

    thread_datapath_top #(
        .DATA_W(8), .ADDR_W(8), .THREAD_ID(0), .BLOCK_ID(0), .BLOCK_DIM(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (bus.pc == 8'd1  && t_pc1  < 0) t_pc1  = cyc;
        if (bus.pc == 8'd4  && t_pc4  < 0) t_pc4  = cyc;
        if (bus.pc == 8'd5  && t_pc5  < 0) t_pc5  = cyc;
        if (bus.pc == 8'd8  && t_pc8  < 0) t_pc8  = cyc;
        if (bus.pc == 8'd9)                saw9   = 1;
        if (bus.pc == 8'd10 && t_pc10 < 0) t_pc10 = cyc;
        if (bus.done === 1'b1 && t_done < 0) t_done = cyc;
    endtask

    task automatic clear_marks();
        cyc = 0;
        t_pc1 = -1; t_pc4 = -1; t_pc5 = -1; t_pc8 = -1; t_pc10 = -1; t_done = -1;
        saw9 = 0;
    endtask

    task automatic check_final(input string sfx);
        check({"done", sfx},    32'(bus.done),        32'd1);
        check({"pc", sfx},      32'(bus.pc),          32'd10);
        check({"retired", sfx}, 32'(bus.retired),     32'd10);
        check({"R2", sfx},      32'(dut.regs_q[2]),   32'd11);
        check({"R3", sfx},      32'(dut.regs_q[3]),   32'd33);
        check({"R4", sfx},      32'(dut.regs_q[4]),   32'd33);
        check({"R5", sfx},      32'(dut.regs_q[5]),   32'd25);
        check({"R6", sfx},      32'(dut.regs_q[6]),   32'd0);
        check({"mem8", sfx},    32'(dut.mem_q[8]),    32'd33);
        check({"nzp", sfx},     32'(dut.nzp_q),       32'd1);
    endtask

    initial begin
        clear_marks();
        repeat (3) @(posedge clock);
        #1;
        check("rst_pc",      32'(bus.pc),      32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_state_fetch", 32'(dut.state_q), 32'd0);
        check("rel_pc",          32'(bus.pc),      32'd0);

        // first run, interrupted in the middle of MUL
        for (int i = 0; i < 4; i++) step();
        check("run1_pc_after4",  32'(bus.pc),          32'd1);
        check("run1_ret_after4", 32'(bus.retired),     32'd1);
        check("run1_R0",         32'(dut.regs_q[0]),   32'd8);
        for (int i = 0; i < 10; i++) step();
        check("run1_pc_after14", 32'(bus.pc),          32'd3);
        check("run1_ret_after14",32'(bus.retired),     32'd3);
        check("run1_R2",         32'(dut.regs_q[2]),   32'd11);

        reset = 1'b1;
        #1;
        check("abort_pc",      32'(bus.pc),        32'd0);
        check("abort_retired", 32'(bus.retired),   32'd0);
        check("abort_done",    32'(bus.done),      32'd0);
        check("abort_R0",      32'(dut.regs_q[0]), 32'd0);
        check("abort_R2",      32'(dut.regs_q[2]), 32'd0);
        check("abort_nzp",     32'(dut.nzp_q),     32'd0);
        @(posedge clock);
        #1;
        check("abort_R3",      32'(dut.regs_q[3]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        clear_marks();

        // full rerun with cycle-accurate timing marks
        while (t_done < 0 && cyc < 200) step();
        check("done_reached",   32'(t_done >= 0), 32'd1);
        check("done_cycle",     32'(t_done),      32'd42);
        check("instr0_cycles",  32'(t_pc1),       32'd4);
        check("pc4_cycle",      32'(t_pc4),       32'd16);
        check("str_cycles",     32'(t_pc5 - t_pc4), 32'd5);
        check("pc8_cycle",      32'(t_pc8),       32'd34);
        check("pc10_cycle",     32'(t_pc10),      32'd38);
        check("pc9_skipped",    32'(saw9),        32'd0);
        check_final("_final");

        for (int i = 0; i < 100; i++) step();
        check_final("_hold");
        check("hold_state_done", 32'(dut.state_q), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
